// File: rtl/truth_table_probe_if.sv
// Stimulus/response bundle between the truth-table probe and the harness around it.
// The master side owns start and the DUT output; the probe (slave) owns pins and results.
interface truth_table_probe_if;
    logic       start_i;
    logic       out_i;
    logic       in1_o;
    logic       in2_o;
    logic       in3_o;
    logic       busy_o;
    logic       done_o;
    logic [7:0] table_o;
    logic [7:0] unstable_o;

    modport master (
        output start_i,
        output out_i,
        input  in1_o,
        input  in2_o,
        input  in3_o,
        input  busy_o,
        input  done_o,
        input  table_o,
        input  unstable_o
    );

    modport slave (
        input  start_i,
        input  out_i,
        output in1_o,
        output in2_o,
        output in3_o,
        output busy_o,
        output done_o,
        output table_o,
        output unstable_o
    );
endinterface

// File: rtl/truth_table_probe.sv
// Walks a 3-input logic block through rows 000..111, samples its synchronized output and
// assembles the 8-bit truth-table code (row 000 in the MSB) plus a per-row instability mask.
module truth_table_probe #(
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned SAMPLES       = 3
) (
    input logic                clk,
    input logic                rst_n,
    truth_table_probe_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StSettle, StSample, StDone} state_e;

    localparam logic [7:0] SettleInit = 8'(SETTLE_CYCLES);
    localparam logic [3:0] SampleInit = 4'(SAMPLES);

    state_e     state_q;
    logic [2:0] row_q;
    logic [7:0] settle_cnt_q;
    logic [3:0] sample_cnt_q;
    logic       ref_q;
    logic       busy_q;
    logic       done_q;
    logic [7:0] table_q;
    logic [7:0] unstable_q;
    logic       sync1_q;
    logic       sync2_q;
    logic [2:0] bit_idx;

    // Row 000 lands in bit 7.
    assign bit_idx = 3'd7 - row_q;

    // DUT output is asynchronous to the probe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= bus.out_i;
            sync2_q <= sync1_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            row_q        <= 3'd0;
            settle_cnt_q <= 8'd0;
            sample_cnt_q <= 4'd0;
            ref_q        <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            table_q      <= 8'h00;
            unstable_q   <= 8'h00;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (bus.start_i) begin
                        state_q      <= StSettle;
                        busy_q       <= 1'b1;
                        row_q        <= 3'd0;
                        table_q      <= 8'h00;
                        unstable_q   <= 8'h00;
                        settle_cnt_q <= SettleInit;
                    end
                end
                StSettle: begin
                    settle_cnt_q <= settle_cnt_q - 8'd1;
                    if (settle_cnt_q == 8'd1) begin
                        state_q      <= StSample;
                        sample_cnt_q <= SampleInit;
                    end
                end
                StSample: begin
                    sample_cnt_q <= sample_cnt_q - 4'd1;
                    // First sample of the row is the reference for the rest.
                    if (sample_cnt_q == SampleInit) begin
                        ref_q <= sync2_q;
                    end else if (sync2_q != ref_q) begin
                        unstable_q[bit_idx] <= 1'b1;
                    end
                    if (sample_cnt_q == 4'd1) begin
                        table_q[bit_idx] <= sync2_q;
                        if (row_q == 3'd7) begin
                            state_q <= StDone;
                            done_q  <= 1'b1;
                            row_q   <= 3'd0;
                        end else begin
                            state_q      <= StSettle;
                            row_q        <= row_q + 3'd1;
                            settle_cnt_q <= SettleInit;
                        end
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.in1_o      = row_q[2];
    assign bus.in2_o      = row_q[1];
    assign bus.in3_o      = row_q[0];
    assign bus.busy_o     = busy_q;
    assign bus.done_o     = done_q;
    assign bus.table_o    = table_q;
    assign bus.unstable_o = unstable_q;

endmodule

// File: tb/tb_truth_table_probe.sv
// Scoreboard bench: two probes (default timing and 2/1 timing) scan behavioural DUTs whose
// truth tables are chosen at random; expected codes are queued at start and checked on done.
module tb_truth_table_probe;

    localparam int unsigned SA = 4;
    localparam int unsigned NA = 3;
    localparam int unsigned SB = 2;
    localparam int unsigned NB = 1;

    typedef struct packed {
        logic [7:0] tbl;
        logic [7:0] unst;
        logic [7:0] mask;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic tog   = 1'b0;
    int   total = 0;
    int   bad   = 0;

    exp_t       sb_q[2][$];
    int         bcnt[2];
    int         done_cnt[2];
    logic [7:0] tt_v[2];
    bit         gl_v[2];
    logic [2:0] row_a;
    logic [2:0] row_b;

    truth_table_probe_if bus_a ();
    truth_table_probe_if bus_b ();

    truth_table_probe #(.SETTLE_CYCLES(SA), .SAMPLES(NA)) dut_a (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus_a.slave)
    );

    truth_table_probe #(.SETTLE_CYCLES(SB), .SAMPLES(NB)) dut_b (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus_b.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) tog <= ~tog;

    // Behavioural DUT: bit (7 - row) of the chosen code; glitch mode toggles on row 011.
    function automatic logic dut_fn(input logic [7:0] tt, input bit gl, input logic [2:0] r,
                                    input logic t);
        if (gl && r == 3'd3) return t;
        return tt[3'd7 - r];
    endfunction

    assign row_a       = {bus_a.in1_o, bus_a.in2_o, bus_a.in3_o};
    assign row_b       = {bus_b.in1_o, bus_b.in2_o, bus_b.in3_o};
    assign bus_a.out_i = dut_fn(tt_v[0], gl_v[0], row_a, tog);
    assign bus_b.out_i = dut_fn(tt_v[1], gl_v[1], row_b, tog);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic mon_step(input int id, input logic busy, input logic done,
                            input logic [2:0] pins, input logic [7:0] tbl,
                            input logic [7:0] unst);
        int unsigned per = (id == 0) ? SA + NA : SB + NB;
        string       p   = (id == 0) ? "a." : "b.";
        exp_t        e;
        if (!rst_n) begin
            bcnt[id] = 0;
            return;
        end
        if (busy) begin
            bcnt[id]++;
            if (done) begin
                chk({p, "done_at"}, bcnt[id], 8 * per + 1);
                chk({p, "done_pins"}, pins, 0);
                chk({p, "sb_pending"}, sb_q[id].size() > 0, 1);
                if (sb_q[id].size() > 0) begin
                    e = sb_q[id].pop_front();
                    chk({p, "table"}, tbl & e.mask, e.tbl & e.mask);
                    chk({p, "unstable"}, unst, e.unst);
                end
                done_cnt[id]++;
            end else begin
                chk({p, "pins"}, pins, (bcnt[id] - 1) / per);
            end
        end else begin
            if (bcnt[id] != 0) chk({p, "busy_len"}, bcnt[id], 8 * per + 1);
            bcnt[id] = 0;
            chk({p, "idle_done"}, done, 0);
            chk({p, "idle_pins"}, pins, 0);
        end
    endtask

    always @(negedge clk) begin
        mon_step(0, bus_a.busy_o, bus_a.done_o, row_a, bus_a.table_o, bus_a.unstable_o);
        mon_step(1, bus_b.busy_o, bus_b.done_o, row_b, bus_b.table_o, bus_b.unstable_o);
    end

    task automatic set_start(input int id, input logic v);
        if (id == 0) bus_a.start_i = v;
        else bus_b.start_i = v;
    endtask

    function automatic exp_t model(input int id, input logic [7:0] tt, input bit glitch);
        exp_t        e;
        int unsigned samples = (id == 0) ? NA : NB;
        e.tbl  = tt;
        // Row 3 is the glitching row: its table bit is phase dependent, its flag needs >1 sample.
        e.mask = glitch ? ~(8'h80 >> 3) : 8'hFF;
        e.unst = (glitch && samples > 1) ? (8'h80 >> 3) : 8'h00;
        return e;
    endfunction

    task automatic wait_done(input int id, input int target, input bit poke);
        int n = 0;
        while (done_cnt[id] < target && n < 400) begin
            @(negedge clk);
            #1;
            n++;
            if (poke && done_cnt[id] < target) set_start(id, $urandom_range(0, 2) == 0);
        end
        chk((id == 0) ? "a.done_count" : "b.done_count", done_cnt[id], target);
        if (poke) begin
            set_start(id, 1'b1);
            @(negedge clk);
            #1;
            set_start(id, 1'b0);
        end
    endtask

    task automatic scan(input int id, input logic [7:0] tt, input bit glitch, input bit poke);
        int prev;
        tt_v[id] = tt;
        gl_v[id] = glitch;
        @(negedge clk);
        #1;
        prev = done_cnt[id];
        set_start(id, 1'b1);
        sb_q[id].push_back(model(id, tt, glitch));
        @(negedge clk);
        #1;
        set_start(id, 1'b0);
        wait_done(id, prev + 1, poke);
    endtask

    task automatic chk_zero_a(input string tag);
        chk({tag, ".busy"}, bus_a.busy_o, 0);
        chk({tag, ".done"}, bus_a.done_o, 0);
        chk({tag, ".pins"}, row_a, 0);
        chk({tag, ".table"}, bus_a.table_o, 0);
        chk({tag, ".unstable"}, bus_a.unstable_o, 0);
    endtask

    initial begin
        int   prev;
        int   n;
        exp_t e;
        tt_v[0]       = 8'h00;
        tt_v[1]       = 8'h00;
        gl_v[0]       = 1'b0;
        gl_v[1]       = 1'b0;
        bcnt[0]       = 0;
        bcnt[1]       = 0;
        done_cnt[0]   = 0;
        done_cnt[1]   = 0;
        bus_a.start_i = 1'b0;
        bus_b.start_i = 1'b0;

        #1 rst_n = 1'b0;
        #1;
        chk_zero_a("rst_a");
        chk("rst_b.table", bus_b.table_o, 0);
        chk("rst_b.busy", bus_b.busy_o, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        scan(0, 8'h4E, 1'b0, 1'b0);
        scan(0, 8'hFF, 1'b0, 1'b0);
        scan(0, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) scan(0, 8'($urandom), 1'b0, 1'b0);
        scan(0, 8'($urandom), 1'b1, 1'b0);

        scan(1, 8'h4E, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) scan(1, 8'($urandom), 1'b0, 1'b0);
        scan(1, 8'($urandom), 1'b1, 1'b0);

        scan(0, 8'($urandom), 1'b0, 1'b1);

        // start held high: three back-to-back scans, one idle cycle between them.
        tt_v[0] = 8'($urandom);
        gl_v[0] = 1'b0;
        e       = model(0, tt_v[0], 1'b0);
        @(negedge clk);
        #1;
        prev = done_cnt[0];
        set_start(0, 1'b1);
        for (int k = 0; k < 3; k++) sb_q[0].push_back(e);
        for (int k = 0; k < 3; k++) begin
            wait_done(0, prev + k + 1, 1'b0);
            if (k == 2) begin
                set_start(0, 1'b0);
            end else begin
                @(negedge clk);
                #1;
                chk("held.gap_idle", bus_a.busy_o, 0);
                @(negedge clk);
                #1;
                chk("held.rearm", bus_a.busy_o, 1);
            end
        end
        repeat (4) @(negedge clk);
        #1;
        chk("held.stopped", bus_a.busy_o, 0);

        // Asynchronous reset while row 101 is on the pins.
        tt_v[0] = 8'($urandom) | 8'hF0;
        @(negedge clk);
        #1;
        set_start(0, 1'b1);
        sb_q[0].push_back(model(0, tt_v[0], 1'b0));
        @(negedge clk);
        #1;
        set_start(0, 1'b0);
        n = 0;
        while (row_a != 3'd5 && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("mid.reached_row5", row_a, 5);
        #1;
        rst_n = 1'b0;
        sb_q[0].delete();
        bcnt[0] = 0;
        #1;
        chk_zero_a("mid_rst");
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        scan(0, 8'($urandom), 1'b0, 1'b0);

        repeat (10) @(negedge clk);
        #1;
        chk("a.sb_empty", sb_q[0].size(), 0);
        chk("b.sb_empty", sb_q[1].size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/truth_table_probe.md
# truth_table_probe

Sequential characterisation engine that drives the three inputs of a 3-input single-output logic block through all eight combinations, samples its output, and assembles the 8-bit truth-table code used to name circuits in the DNACompiler Wolfram set (for example 0x4E). It is the reading end of the truth-table description: a combinational function block is the device under test (DUT), and this probe recovers its hex code plus a per-row stability mask. It sits in the verification/characterisation harness beside the DUT.

## Interface
- SETTLE_CYCLES, default 4: cycles each input row is held before sampling starts. Legal range is 2..255, which covers the 2-flop synchronizer.
- SAMPLES, default 3: consecutive samples taken per row. Legal range is 1..15.
- clk  input  1  single clock; all state changes on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request a scan; accepted only in IDLE.
- out  input  1  DUT output; asynchronous to the probe, passed through a 2-flop synchronizer (out_s) before any use.
- in1, in2, in3  output  1 each  DUT stimulus, registered; {in1,in2,in3} = current row index.
- busy  output  1  high from start acceptance through the DONE cycle.
- done  output  1  one-cycle pulse when a scan completes.
- table  output  8  truth-table code; table[7-r] = DUT output for row r, so row 000 maps to the MSB.
- unstable  output  8  unstable[7-r] = 1 if the SAMPLES samples of row r disagreed.

## Operation
- States: IDLE, SETTLE, SAMPLE, DONE.
- **IDLE:** {in1,in2,in3}=000, busy=0.
  - start=1 → row=0, table=0, unstable=0, settle counter=SETTLE_CYCLES, next state SETTLE.
- **SETTLE:** inputs drive row; counter decrements each cycle.
  - After SETTLE_CYCLES cycles in SETTLE → next state SAMPLE, sample counter=SAMPLES.
- **SAMPLE:** each cycle captures out_s.
  - The first sample of the row becomes the reference; any later sample differing from it sets unstable[7-row].
  - On the final sample edge: table[7-row] = last sample.
  - If row=7 → next state DONE; else row+1 and return to SETTLE. There is no idle cycle between rows.
- **DONE:** done=1 for exactly one cycle; inputs return to 000; then IDLE.
- table and unstable hold their values until the next accepted start clears them.
- start is ignored in SETTLE, SAMPLE and DONE. start held high re-arms only from IDLE, which gives back-to-back scans separated by one IDLE cycle.
- Counter widths are 8 bits (settle) and 4 bits (sample); no wrap occurs within legal parameter ranges.
- Row counter is 3 bits; the increment past 7 never occurs because row 7 exits to DONE.
- **rst_n low, at any time including mid-scan:** takes effect immediately and asynchronously.
  - State=IDLE; in1..in3=0; busy=0; done=0; table=0x00; unstable=0x00; synchronizer flops and counters=0.
  - No partial results survive reset.

## Timing
- Reset values: in1=in2=in3=0, busy=0, done=0, table=0x00, unstable=0x00.
- Start accepted at edge E0. Row 0 appears on the input pins and busy rises after E0.
- Each row occupies exactly SETTLE_CYCLES+SAMPLES cycles on the pins.
- done is high between edges E0+8·(SETTLE_CYCLES+SAMPLES) and E0+8·(SETTLE_CYCLES+SAMPLES)+1.
- busy falls with done.
- With defaults, done is high 56 cycles after E0.
- Sampling of row r reflects DUT output only if DUT propagation delay plus 2 synchronizer cycles ≤ SETTLE_CYCLES. Meeting this is a user constraint; the probe does not detect violations.
- table bit for row r is updated on row r's final sample edge. table is final in the cycle done=1.

## Test plan
- **Behavioural 0x4E DUT** (rows 000..111 → 0,1,0,0,1,1,1,0), defaults, one start pulse → done 56 cycles later, table=0x4E, unstable=0x00, busy high exactly 57 cycles.
- **Constant DUTs:**
  - out=1 → table=0xFF, unstable=0x00.
  - out=0 → table=0x00, unstable=0x00.
- **Pin sequence check:** SETTLE_CYCLES=2, SAMPLES=1 → {in1,in2,in3} steps 000,001,…,111, each held exactly 3 cycles, then returns to 000 in the DONE cycle.
- **Glitch:**
  - DUT toggles out every cycle only while row=011, SAMPLES=3 → unstable=0x10, all other bits 0.
  - With SAMPLES=1 the same stimulus gives unstable=0x00.
- **Reset mid-scan:** rst_n pulsed low during row 101 → all outputs 0 immediately, without waiting for a clock edge. A following start gives a full correct scan beginning at row 000.
- **start misuse:**
  - Extra start pulses during SETTLE/SAMPLE/DONE → no effect, one done per scan.
  - start held high continuously → repeated scans, each done followed by exactly one IDLE cycle, table identical each scan.
